// File: rtl/latch_write_ctrl.sv
// Write sequencer for the 8-bit transparent output latch: byte FIFO plus a timed setup/strobe/hold FSM.
// Optional macro LATCH_WRITE_CTRL_BLANK_EN forces latchnOE high during every STROBE cycle.
module latch_write_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [7:0]                         wrData,
   input  logic                               wrValid,
   output logic                               wrReady,
   input  logic                               outEnable,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending,
   output logic [7:0]                         latchData,
   output logic                               latchLE,
   output logic                               latchnOE
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } stateType;

   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [CW-1:0] count;
   stateType      state;
   stateType      stateNext;
   logic [7:0]    phaseCnt;
   logic [7:0]    phaseCntNext;
   logic [7:0]    dataNext;
   logic          leNext;
   logic          nOeNext;
   logic          push;
   logic          pop;

   assign wrReady = (count != CW'(FIFO_DEPTH));
   assign push    = wrValid && wrReady;
   assign pending = count;
   assign busy    = (state != IDLE) || (count != {CW{1'b0}});

   // FIFO storage; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr] <= wrData;
      end
   end

   // Next-state, phase counter, latch outputs and FIFO pop decision
   always_comb begin
      stateNext    = state;
      phaseCntNext = phaseCnt;
      dataNext     = latchData;
      leNext       = latchLE;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            leNext = 1'b0;
            if (count != {CW{1'b0}}) begin
               pop          = 1'b1;
               dataNext     = fifoMem[rdPtr];
               stateNext    = SETUP;
               phaseCntNext = 8'(SETUP_CYC - 1);
            end else begin
               stateNext = IDLE;
            end
         end
         SETUP: begin
            if (phaseCnt == 8'd0) begin
               stateNext    = STROBE;
               leNext       = 1'b1;
               phaseCntNext = 8'(STROBE_CYC - 1);
            end else begin
               leNext       = 1'b0;
               phaseCntNext = phaseCnt - 8'd1;
            end
         end
         STROBE: begin
            if (phaseCnt == 8'd0) begin
               stateNext    = HOLD;
               leNext       = 1'b0;
               phaseCntNext = 8'(HOLD_CYC - 1);
            end else begin
               leNext       = 1'b1;
               phaseCntNext = phaseCnt - 8'd1;
            end
         end
         HOLD: begin
            leNext = 1'b0;
            if (phaseCnt == 8'd0) begin
               stateNext    = IDLE;
               phaseCntNext = 8'd0;
            end else begin
               phaseCntNext = phaseCnt - 8'd1;
            end
         end
         default: begin
            stateNext    = IDLE;
            leNext       = 1'b0;
            phaseCntNext = 8'd0;
         end
      endcase
`ifdef LATCH_WRITE_CTRL_BLANK_EN
      // Keyed on stateNext so the blanking register lines up exactly with the LE-high cycles
      if (stateNext == STROBE) begin
         nOeNext = 1'b1;
      end else begin
         nOeNext = ~outEnable;
      end
`else
      nOeNext = ~outEnable;
`endif
   end

   // State, counter, FIFO bookkeeping and registered latch outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phaseCnt  <= 8'd0;
         latchData <= 8'h00;
         latchLE   <= 1'b0;
         latchnOE  <= 1'b1;
         wrPtr     <= {PW{1'b0}};
         rdPtr     <= {PW{1'b0}};
         count     <= {CW{1'b0}};
      end else begin
         state     <= stateNext;
         phaseCnt  <= phaseCntNext;
         latchData <= dataNext;
         latchLE   <= leNext;
         latchnOE  <= nOeNext;
         if (push) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Self-checking bench for latch_write_ctrl: per-scenario tasks with a byte scoreboard fed at write acceptance.
module tb_latch_write_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] wrData = 8'h00;
   logic       wrValid = 1'b0;
   logic       wrReady;
   logic       outEnable = 1'b0;
   logic       busy;
   logic [2:0] pending;
   logic [7:0] latchData;
   logic       latchLE;
   logic       latchnOE;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic prevLE = 1'b0;
   logic [7:0] expQ[$];
   logic [7:0] obsQ[$];
   int riseCyc[$];

   latch_write_ctrl dut (
      .clk(clk), .rst(rst), .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
      .outEnable(outEnable), .busy(busy), .pending(pending), .latchData(latchData),
      .latchLE(latchLE), .latchnOE(latchnOE)
   );

   always #5 clk = ~clk;

   // Advance one edge, sample 1ns later and record every LE rising edge with its byte
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (latchLE === 1'b1 && prevLE === 1'b0) begin
         obsQ.push_back(latchData);
         riseCyc.push_back(cyc);
      end
      prevLE = latchLE;
   endtask

   task automatic test_reset();
      int leSeen;
      logic [7:0] o;
      logic [7:0] e;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      total++; if (latchnOE !== 1'b1 || latchLE !== 1'b0 || latchData !== 8'h00) begin bad++; $display("FAIL por_outputs: nOE=%0b LE=%0b data=%h, want 1 0 00", latchnOE, latchLE, latchData); end
      total++; if (pending !== 3'd0 || wrReady !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL por_status: pending=%0d ready=%0b busy=%0b, want 0 1 0", pending, wrReady, busy); end
      wrValid = 1'b1;
      wrData = 8'h77; expQ.push_back(8'h77); tick();
      wrData = 8'h88; expQ.push_back(8'h88); tick();
      wrData = 8'h99; expQ.push_back(8'h99); tick();
      wrValid = 1'b0;
      total++; if (latchLE !== 1'b1) begin bad++; $display("FAIL rst_pre_strobe: LE=%0b, want 1", latchLE); end
      rst = 1'b1; tick();
      total++; if (latchLE !== 1'b0) begin bad++; $display("FAIL rst_le_drop: LE=%0b, want 0", latchLE); end
      total++; if (latchnOE !== 1'b1 || latchData !== 8'h00) begin bad++; $display("FAIL rst_outputs: nOE=%0b data=%h, want 1 00", latchnOE, latchData); end
      total++; if (pending !== 3'd0 || wrReady !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_status: pending=%0d ready=%0b busy=%0b, want 0 1 0", pending, wrReady, busy); end
      while (obsQ.size() > 0) begin
         o = obsQ.pop_front(); e = expQ.pop_front();
         total++; if (o !== e) begin bad++; $display("FAIL rst_sb_byte: got %h, want %h", o, e); end
      end
      expQ.delete();
      tick(); rst = 1'b0;
      leSeen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (latchLE === 1'b1) leSeen++;
      end
      total++; if (leSeen != 0 || obsQ.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_discard: LE-high cycles=%0d writes=%0d busy=%0b, want 0 0 0", leSeen, obsQ.size(), busy); end
   endtask

   task automatic test_single();
      logic expLe [1:5];
      logic [7:0] o;
      logic [7:0] e;
      expLe[1] = 1'b0; expLe[2] = 1'b1; expLe[3] = 1'b1; expLe[4] = 1'b0; expLe[5] = 1'b0;
      riseCyc.delete();
      wrValid = 1'b1; wrData = 8'hA5; expQ.push_back(8'hA5);
      tick();
      wrValid = 1'b0;
      total++; if (pending !== 3'd1 || latchData !== 8'h00) begin bad++; $display("FAIL single_e0: pending=%0d data=%h, want 1 00", pending, latchData); end
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) begin
            total++; if (latchData !== 8'hA5 || busy !== 1'b1 || pending !== 3'd0) begin bad++; $display("FAIL single_e1: data=%h busy=%0b pending=%0d, want a5 1 0", latchData, busy, pending); end
         end
         total++; if (latchLE !== expLe[k]) begin bad++; $display("FAIL single_le_e%0d: LE=%0b, want %0b", k, latchLE, expLe[k]); end
         if (k == 4) begin
            total++; if (busy !== 1'b1 || latchData !== 8'hA5) begin bad++; $display("FAIL single_e4: busy=%0b data=%h, want 1 a5", busy, latchData); end
         end
      end
      total++; if (busy !== 1'b0 || latchData !== 8'hA5) begin bad++; $display("FAIL single_e5: busy=%0b data=%h, want 0 a5", busy, latchData); end
      while (obsQ.size() > 0) begin
         o = obsQ.pop_front();
         total++;
         if (expQ.size() == 0) begin bad++; $display("FAIL single_sb_extra: got %h, want none", o); end
         else begin e = expQ.pop_front(); if (o !== e) begin bad++; $display("FAIL single_sb_byte: got %h, want %h", o, e); end end
      end
      total++; if (expQ.size() != 0) begin bad++; $display("FAIL single_sb_missing: %0d left, want 0", expQ.size()); end
   endtask

   task automatic test_burst();
      int i;
      int guard;
      int sawFull;
      logic [7:0] o;
      logic [7:0] e;
      riseCyc.delete();
      i = 0; guard = 0; sawFull = 0;
      wrValid = 1'b1;
      while (i < 6 && guard < 200) begin
         wrData = 8'(i + 1);
         if (wrReady === 1'b1) begin
            expQ.push_back(8'(i + 1));
            tick();
            i++;
         end else begin
            sawFull = 1;
            total++; if (pending !== 3'd4) begin bad++; $display("FAIL burst_full_level: pending=%0d with ready low, want 4", pending); end
            tick();
         end
         guard++;
      end
      wrValid = 1'b0;
      total++; if (i != 6 || sawFull != 1) begin bad++; $display("FAIL burst_accept: accepted=%0d sawFull=%0d, want 6 1", i, sawFull); end
      guard = 0;
      while (busy === 1'b1 && guard < 200) begin tick(); guard++; end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_drain: busy=%0b after %0d cycles, want 0", busy, guard); end
      total++; if (riseCyc.size() != 6) begin bad++; $display("FAIL burst_count: writes=%0d, want 6", riseCyc.size()); end
      for (int k = 1; k < riseCyc.size(); k++) begin
         total++; if (riseCyc[k] - riseCyc[k-1] != 5) begin bad++; $display("FAIL burst_spacing: gap=%0d, want 5", riseCyc[k] - riseCyc[k-1]); end
      end
      while (obsQ.size() > 0) begin
         o = obsQ.pop_front();
         total++;
         if (expQ.size() == 0) begin bad++; $display("FAIL burst_sb_extra: got %h, want none", o); end
         else begin e = expQ.pop_front(); if (o !== e) begin bad++; $display("FAIL burst_sb_byte: got %h, want %h", o, e); end end
      end
      total++; if (expQ.size() != 0) begin bad++; $display("FAIL burst_sb_missing: %0d left, want 0", expQ.size()); end
   endtask

   task automatic test_push_pop();
      int guard;
      logic [7:0] o;
      logic [7:0] e;
      riseCyc.delete();
      wrValid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wrData = 8'(8'h40 + k); expQ.push_back(8'(8'h40 + k)); tick();
      end
      wrValid = 1'b0;
      total++; if (pending !== 3'd2) begin bad++; $display("FAIL pp_pre: pending=%0d, want 2", pending); end
      tick(); tick(); tick();
      total++; if (pending !== 3'd2) begin bad++; $display("FAIL pp_hold: pending=%0d, want 2", pending); end
      wrValid = 1'b1; wrData = 8'h43; expQ.push_back(8'h43);
      tick();
      wrValid = 1'b0;
      total++; if (pending !== 3'd2 || latchData !== 8'h41) begin bad++; $display("FAIL pp_simul: pending=%0d data=%h, want 2 41", pending, latchData); end
      guard = 0;
      while (busy === 1'b1 && guard < 200) begin tick(); guard++; end
      total++; if (busy !== 1'b0 || riseCyc.size() != 4) begin bad++; $display("FAIL pp_drain: busy=%0b writes=%0d, want 0 4", busy, riseCyc.size()); end
      while (obsQ.size() > 0) begin
         o = obsQ.pop_front();
         total++;
         if (expQ.size() == 0) begin bad++; $display("FAIL pp_sb_extra: got %h, want none", o); end
         else begin e = expQ.pop_front(); if (o !== e) begin bad++; $display("FAIL pp_sb_byte: got %h, want %h", o, e); end end
      end
      total++; if (expQ.size() != 0) begin bad++; $display("FAIL pp_sb_missing: %0d left, want 0", expQ.size()); end
   endtask

   task automatic test_oe_pulse();
      logic want;
      total++; if (latchnOE !== 1'b1) begin bad++; $display("FAIL oe_idle: nOE=%0b, want 1", latchnOE); end
      outEnable = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         want = (k <= 3) ? 1'b0 : 1'b1;
         total++; if (latchnOE !== want) begin bad++; $display("FAIL oe_pulse_c%0d: nOE=%0b, want %0b", k, latchnOE, want); end
         if (k == 3) outEnable = 1'b0;
      end
   endtask

   task automatic test_blank();
      int guard;
      int highCnt;
      logic want;
      logic [7:0] o;
      logic [7:0] e;
      outEnable = 1'b1; tick(); tick();
      wrValid = 1'b1; wrData = 8'h3C; expQ.push_back(8'h3C);
      tick();
      wrValid = 1'b0;
      highCnt = 0;
      for (int k = 1; k <= 7; k++) begin
         tick();
`ifdef LATCH_WRITE_CTRL_BLANK_EN
         want = (k == 2 || k == 3) ? 1'b1 : 1'b0;
`else
         want = 1'b0;
`endif
         if (latchnOE === 1'b1) highCnt++;
         total++; if (latchnOE !== want) begin bad++; $display("FAIL blank_e%0d: nOE=%0b LE=%0b, want nOE=%0b", k, latchnOE, latchLE, want); end
      end
`ifdef LATCH_WRITE_CTRL_BLANK_EN
      total++; if (highCnt != 2) begin bad++; $display("FAIL blank_count: high cycles=%0d, want 2", highCnt); end
`else
      total++; if (highCnt != 0) begin bad++; $display("FAIL blank_count: high cycles=%0d, want 0", highCnt); end
`endif
      outEnable = 1'b0;
      guard = 0;
      while (busy === 1'b1 && guard < 200) begin tick(); guard++; end
      while (obsQ.size() > 0) begin
         o = obsQ.pop_front();
         total++;
         if (expQ.size() == 0) begin bad++; $display("FAIL blank_sb_extra: got %h, want none", o); end
         else begin e = expQ.pop_front(); if (o !== e) begin bad++; $display("FAIL blank_sb_byte: got %h, want %h", o, e); end end
      end
      total++; if (expQ.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL blank_sb_missing: %0d left busy=%0b, want 0 0", expQ.size(), busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_push_pop();
      test_oe_pulse();
      test_blank();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/latch_write_ctrl.md
# latch_write_ctrl

Upstream write sequencer for the 8-bit transparent output latch. It accepts bytes over a valid/ready port into a small FIFO and replays each byte onto the latch data bus with a timed setup / LE-strobe / hold sequence. It also drives the latch's active-low output enable from a registered request. It sits between the processing logic and the latch, and is the only block allowed to toggle LE.

## Interface
- FIFO_DEPTH, 4, byte FIFO depth; power of two, 2..16
- SETUP_CYC, 1, cycles data is stable before LE rises; 1..255
- STROBE_CYC, 2, cycles LE is held high; 1..255
- HOLD_CYC, 1, cycles data is held after LE falls; 1..255

- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- wrData  input  8  byte to write
- wrValid  input  1  wrData valid
- wrReady  output  1  FIFO can accept; transfer when wrValid && wrReady
- outEnable  input  1  request latch outputs driven
- busy  output  1  sequence in progress or FIFO non-empty
- pending  output  $clog2(FIFO_DEPTH+1)  bytes held in FIFO
- latchData  output  8  to latch inData
- latchLE  output  1  to latch LE
- latchnOE  output  1  to latch nOE

## Operation
- Reset (rst high at an edge) gives latchData=8'h00, latchLE=0, latchnOE=1, pending=0, wrReady=1, busy=0, FSM=IDLE, FIFO pointers=0. Reset mid-sequence aborts immediately, drops LE on that edge, and discards FIFO contents.
- FIFO: circular, wrap-around pointers; wrReady = (pending != FIFO_DEPTH), combinational from registered count.
  - A push when full cannot occur.
  - A simultaneous push and pop leaves pending unchanged.
  - A push into an empty FIFO is not visible to the FSM until the next cycle (no bypass).
- FSM states and transitions:
  - IDLE: if pending != 0, pop head into latchData and go to SETUP; otherwise stay. latchLE=0.
  - SETUP: latchLE=0 for SETUP_CYC cycles, then go to STROBE.
  - STROBE: latchLE=1 for STROBE_CYC cycles, then go to HOLD.
  - HOLD: latchLE=0 for HOLD_CYC cycles, then go to IDLE.
- latchData changes only on the IDLE→SETUP edge; it is stable through SETUP, STROBE and HOLD.
- latchLE is a registered output; it never glitches.
- busy = (FSM != IDLE) || (pending != 0).
- latchnOE <= ~outEnable, registered with 1 cycle latency and independent of the FSM (see Configuration).
- Phase timing uses a single 8-bit down-counter, loaded with N-1 on entry to each phase.

## Timing
- Write accepted at edge E0. IDLE pops at E1. latchLE rises at E1+SETUP_CYC and falls at E1+SETUP_CYC+STROBE_CYC. FSM returns to IDLE at E1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
- Back-to-back throughput: one byte per 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; 5 cycles with defaults.
- outEnable change appears on latchnOE 1 cycle later.
- An empty FIFO in IDLE holds all outputs; latchData keeps the last byte.

## Configuration
- LATCH_WRITE_CTRL_BLANK_EN
  - Defined: latchnOE is forced to 1 during every STROBE cycle, regardless of outEnable, so the transparent phase is never visible on the pins. Normal registered ~outEnable resumes on the first HOLD cycle.
  - Undefined: latchnOE strictly follows ~outEnable delayed by 1 cycle; the strobe is visible through the latch.

## Test plan
- Reset: hold rst 2 cycles during an active STROBE -> latchLE=0 at the reset edge; latchnOE=1, latchData=8'h00, pending=0, wrReady=1, busy=0; nothing further is written.
- Single write of 8'hA5 with defaults at E0 -> latchData=8'hA5 at E1; latchLE high for exactly edges E2..E4 (rises at E2, falls at E4); busy falls at E5.
- Burst of 6 bytes 8'h01..8'h06 with wrValid held high -> wrReady drops when pending=4. All 6 bytes appear on latchData in order, one per 5 cycles. No byte is lost or duplicated across pointer wrap.
- Simultaneous push and pop with pending=2 -> pending stays 2; ordering is preserved.
- outEnable 0→1→0 pulse of 3 cycles -> latchnOE low for exactly 3 cycles, lagging outEnable by 1 cycle.
- With LATCH_WRITE_CTRL_BLANK_EN defined, outEnable=1 and a write of 8'h3C -> latchnOE=1 for exactly the 2 STROBE cycles and 0 otherwise. Without the macro, latchnOE stays 0 throughout.
